bit_position_sequencer: RTL and testbench
=========================================

BIT_POSITION_SEQUENCER -- requirements
Module: bit_position_sequencer

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-low reset (0 = reset).
REQ-003 SHALL have ports: in_valid  input  1  upstream offers a mask.
REQ-004 SHALL have ports: in_ready  output  1  block accepts the mask this cycle.
REQ-005 SHALL have ports: in_mask  input  16  operand bitmask; bit 15 is MSB.
REQ-006 SHALL have ports: out_valid  output  1  out_pos/out_idx/out_last/out_zero are valid.
REQ-007 SHALL have ports: out_ready  input  1  downstream consumes the current beat.
REQ-008 SHALL have ports: out_pos  output  4  bit index (15..0) of the set bit emitted this beat.
REQ-009 SHALL have ports: out_idx  output  4  ordinal of this beat within the mask, 0-based.
REQ-010 SHALL have ports: out_last  output  1  final beat for the current mask.
REQ-011 SHALL have ports: out_zero  output  1  accepted mask was all-zero; out_pos = 0.

Function
REQ-012 SHALL emit one beat per set bit of an accepted mask, MSB-first (highest index first).
REQ-013 SHALL implement FSM states IDLE and BUSY; reset enters IDLE.
REQ-014 IDLE: in_ready = 1 and out_valid = 0.
REQ-015 IDLE with in_valid = 1: SHALL register the mask, clear out_idx to 0, and enter BUSY next cycle.
REQ-016 BUSY: out_valid = 1 continuously. out_pos = leading-one index of the remaining mask register, from combinational logic on registered state.
REQ-017 BUSY: out_last = 1 when the remaining mask has exactly one set bit or is zero.
REQ-018 A beat completes on out_valid & out_ready. The block SHALL then clear bit out_pos in the remaining mask and increment out_idx (4-bit, no wrap needed: at most 16 beats, idx 15 maximum).
REQ-019 out_valid and all out_* SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-020 Zero mask: SHALL produce exactly one beat with out_zero = 1, out_last = 1, out_pos = 0, out_idx = 0.
REQ-021 BUSY: in_ready = out_valid & out_ready & out_last, so a new mask is accepted in the same cycle the final beat completes.
REQ-022 When the final beat completes with in_valid = 1: SHALL load the new mask, reset out_idx, and remain BUSY, giving zero-bubble back-to-back operation.
REQ-023 When the final beat completes with in_valid = 0: SHALL return to IDLE.
REQ-024 Throughput: SHALL sustain 1 beat/cycle with out_ready held high. Latency from mask acceptance to the first out_valid SHALL be 1 cycle.
REQ-025 in_mask SHALL be ignored while in_ready = 0, and no input SHALL be lost or duplicated.

Reset
REQ-026 reset = 0 at a clk edge SHALL force state IDLE, remaining mask 0, out_idx 0, out_valid 0, out_last 0, out_zero 0, out_pos 0, in_ready 1 (after the edge).
REQ-027 Reset mid-sequence SHALL abandon the remaining beats; no further beat of that mask SHALL appear.
REQ-028 Reset SHALL take precedence over any simultaneous handshake.

Structure
REQ-029 A shared package SHALL hold MASK_W = 16, POS_W = 4, and the state enum type (IDLE, BUSY).
REQ-030 Leading-one detection SHALL be one combinational sub-module, lead_one_detect_16 (16-bit in, 4-bit index, zero flag), instantiated once.

Verification
REQ-031 Sequence test: mask 0x8421, out_ready = 1 -> beats pos 15, 10, 5, 0; idx 0..3; last only on pos 0; out_valid first seen 1 cycle after acceptance.
REQ-032 Zero mask: mask 0x0000 -> single beat, out_zero = 1, out_last = 1, pos 0, idx 0; then IDLE.
REQ-033 Full mask: 0xFFFF -> 16 beats, pos 15..0, idx 0..15, last on idx 15.
REQ-034 Backpressure: mask 0x0300 with out_ready toggling 1,0,0,1 -> pos 9 then pos 8, outputs stable during stall, no beat dropped.
REQ-035 Back-to-back: 0x0001 then 0x8000, in_valid held, out_ready = 1 -> pos 0 (last) and pos 15 (last) in consecutive cycles with no bubble.
REQ-036 Reset mid-sequence: reset = 0 after the 2nd beat of 0x00F0 -> out_valid = 0 the next cycle, no pos 5/4 beats; next mask 0x0002 -> single beat pos 1.

Source files
------------

// File: rtl/bit_position_sequencer_pkg.sv
// Shared widths, state encoding and a small mask helper for the bit position sequencer.
package bit_position_sequencer_pkg;

  localparam int MASK_W = 16;
  localparam int POS_W  = 4;

  // FSM encoding: plain constants for the state register, enum for the debug view.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // True when the mask has zero or one bit set; clearing the lowest set bit leaves nothing.
  function automatic logic at_most_one(input logic [MASK_W-1:0] m);
    logic [MASK_W-1:0] one;
    one = {{(MASK_W-1){1'b0}}, 1'b1};
    return ((m & (m - one)) == '0);
  endfunction

endpackage

// File: rtl/bit_position_sequencer_if.sv
// Mask-in / beat-out bus of the bit position sequencer.
//
// Handshake: on both channels a transfer happens on a rising clk edge where
// valid & ready are both 1. A producer holding valid keeps its payload stable
// until the transfer; valid never depends combinationally on ready on the
// producer side (here in_ready may depend on out_ready, never the reverse).
interface bit_position_sequencer_if;
  import bit_position_sequencer_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [MASK_W-1:0] in_mask;
  logic              out_valid;
  logic              out_ready;
  logic [POS_W-1:0]  out_pos;
  logic [POS_W-1:0]  out_idx;
  logic              out_last;
  logic              out_zero;

  // Environment side: offers masks, consumes beats.
  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_pos, out_idx, out_last, out_zero
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_pos, out_idx, out_last, out_zero
  );
endinterface

// File: rtl/bit_position_sequencer_lead_one_detect_16.sv
// Combinational leading-one detector: index of the highest set bit, plus all-zero flag.
module lead_one_detect_16
  import bit_position_sequencer_pkg::*;
(
  input  logic [MASK_W-1:0] mask,
  output logic [POS_W-1:0]  pos,
  output logic              zero
);

  // Scan upward so the highest set bit is the last (winning) assignment; 0 when empty.
  always_comb begin
    pos = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask[i]) pos = i[POS_W-1:0];
    end
  end

  assign zero = ~|mask;

endmodule

// File: rtl/bit_position_sequencer.sv
// Emits one beat per set bit of each accepted 16-bit mask, highest index first.
// A zero mask yields a single beat flagged out_zero. The next mask can be taken
// in the same cycle the final beat completes, so back-to-back masks have no bubble.
module bit_position_sequencer
  import bit_position_sequencer_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  bit_position_sequencer_if.slave   bus,
  output state_e                    state_dbg
);

  logic [0:0]        state;
  logic [MASK_W-1:0] rem;
  logic [POS_W-1:0]  idx;

  logic [POS_W-1:0]  lead_pos;
  logic              rem_zero;
  logic              busy;
  logic              last;
  logic              fire;
  logic              accept;
  logic [MASK_W-1:0] clear_bit;

  lead_one_detect_16 u_lod (
    .mask (rem),
    .pos  (lead_pos),
    .zero (rem_zero)
  );

  assign busy   = (state == ST_BUSY);
  assign last   = busy & at_most_one(rem);
  assign fire   = busy & bus.out_ready;
  assign accept = bus.in_valid & bus.in_ready;

  // One-hot of the bit being emitted, removed from the remaining mask on completion.
  assign clear_bit = {{(MASK_W-1){1'b0}}, 1'b1} << lead_pos;

  assign bus.in_ready  = ~busy | (fire & last);
  assign bus.out_valid = busy;
  assign bus.out_pos   = lead_pos;
  assign bus.out_idx   = idx;
  assign bus.out_last  = last;
  assign bus.out_zero  = busy & rem_zero;

  assign state_dbg = state_e'(state);

  // State, remaining mask and beat ordinal; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      rem   <= '0;
      idx   <= '0;
    end else if (accept) begin
      state <= ST_BUSY;
      rem   <= bus.in_mask;
      idx   <= '0;
    end else if (fire) begin
      if (last) begin
        state <= ST_IDLE;
        rem   <= '0;
        idx   <= '0;
      end else begin
        rem <= rem & ~clear_bit;
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bit_position_sequencer.sv
// Directed bench for bit_position_sequencer: inputs driven and outputs checked on the falling edge.
module tb_bit_position_sequencer;
  import bit_position_sequencer_pkg::*;

  logic   clk;
  logic   reset;
  state_e state_dbg;
  int     tests;
  int     fails;

  bit_position_sequencer_if bus();

  bit_position_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Clock and initial input levels
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one full cycle, landing on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_mask = 16'h0000;
    bus.out_ready = 1'b0;
    @(negedge clk);
    step();
    step();
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_zero !== 1'b0) begin
      fails++; $display("FAIL reset_flags got v%b l%b z%b want 000", bus.out_valid, bus.out_last, bus.out_zero);
    end
    tests++;
    if (bus.out_pos !== 4'd0 || bus.out_idx !== 4'd0) begin
      fails++; $display("FAIL reset_pos_idx got pos %0d idx %0d want 0 0", bus.out_pos, bus.out_idx);
    end
    tests++;
    if (state_dbg !== IDLE) begin fails++; $display("FAIL reset_state got %0d want IDLE", state_dbg); end
    reset = 1'b1;
    step();
  endtask

  // Offer one mask from idle and check it is taken, with out_valid one cycle later.
  task automatic offer_mask(input logic [15:0] m, input string name);
    bus.in_valid = 1'b1;
    bus.in_mask = m;
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL %s_accept in_ready %b want 1", name, bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    bus.in_mask = 16'hDEAD;
    tests++;
    if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL %s_latency out_valid %b want 1", name, bus.out_valid); end
  endtask

  task automatic test_sequence();
    logic [3:0] exp_pos [4];
    exp_pos[0] = 4'd15; exp_pos[1] = 4'd10; exp_pos[2] = 4'd5; exp_pos[3] = 4'd0;
    bus.out_ready = 1'b1;
    offer_mask(16'h8421, "seq");
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_pos !== exp_pos[k] || bus.out_idx !== k[3:0]
          || bus.out_last !== (k == 3) || bus.out_zero !== 1'b0) begin
        fails++;
        $display("FAIL seq_beat%0d got v%b pos %0d idx %0d last %b zero %b want v1 pos %0d idx %0d last %b zero 0",
                 k, bus.out_valid, bus.out_pos, bus.out_idx, bus.out_last, bus.out_zero, exp_pos[k], k, k == 3);
      end
      step();
    end
    tests++;
    if (bus.out_valid !== 1'b0 || state_dbg !== IDLE) begin
      fails++; $display("FAIL seq_done out_valid %b state %0d want 0 IDLE", bus.out_valid, state_dbg);
    end
  endtask

  task automatic test_zero_mask();
    bus.out_ready = 1'b1;
    offer_mask(16'h0000, "zero");
    tests++;
    if (bus.out_zero !== 1'b1 || bus.out_last !== 1'b1 || bus.out_pos !== 4'd0 || bus.out_idx !== 4'd0) begin
      fails++; $display("FAIL zero_beat got zero %b last %b pos %0d idx %0d want 1 1 0 0",
                        bus.out_zero, bus.out_last, bus.out_pos, bus.out_idx);
    end
    step();
    tests++;
    if (bus.out_valid !== 1'b0 || state_dbg !== IDLE || bus.out_zero !== 1'b0) begin
      fails++; $display("FAIL zero_done out_valid %b state %0d zero %b want 0 IDLE 0", bus.out_valid, state_dbg, bus.out_zero);
    end
  endtask

  task automatic test_full_mask();
    bus.out_ready = 1'b1;
    offer_mask(16'hFFFF, "full");
    for (int k = 0; k < 16; k++) begin
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_pos !== 4'(15 - k) || bus.out_idx !== k[3:0]
          || bus.out_last !== (k == 15)) begin
        fails++;
        $display("FAIL full_beat%0d got v%b pos %0d idx %0d last %b want v1 pos %0d idx %0d last %b",
                 k, bus.out_valid, bus.out_pos, bus.out_idx, bus.out_last, 15 - k, k, k == 15);
      end
      step();
    end
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL full_done out_valid %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic       rdy     [4];
    logic [3:0] exp_pos [4];
    logic [3:0] exp_idx [4];
    rdy[0] = 1'b1; rdy[1] = 1'b0; rdy[2] = 1'b0; rdy[3] = 1'b1;
    exp_pos[0] = 4'd9; exp_pos[1] = 4'd8; exp_pos[2] = 4'd8; exp_pos[3] = 4'd8;
    exp_idx[0] = 4'd0; exp_idx[1] = 4'd1; exp_idx[2] = 4'd1; exp_idx[3] = 4'd1;
    bus.out_ready = 1'b1;
    offer_mask(16'h0300, "bp");
    for (int k = 0; k < 4; k++) begin
      bus.out_ready = rdy[k];
      // A competing mask during the stall must be refused.
      bus.in_valid = (k == 1 || k == 2);
      bus.in_mask = 16'hFFFF;
      #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_pos !== exp_pos[k] || bus.out_idx !== exp_idx[k]
          || bus.out_last !== (k != 0)) begin
        fails++;
        $display("FAIL bp_cycle%0d got v%b pos %0d idx %0d last %b want v1 pos %0d idx %0d last %b",
                 k, bus.out_valid, bus.out_pos, bus.out_idx, bus.out_last, exp_pos[k], exp_idx[k], k != 0);
      end
      if (k == 1 || k == 2) begin
        tests++;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall_ready%0d in_ready %b want 0", k, bus.in_ready); end
      end
      step();
    end
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || state_dbg !== IDLE) begin
      fails++; $display("FAIL bp_done out_valid %b state %0d want 0 IDLE", bus.out_valid, state_dbg);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_mask = 16'h0001;
    step();
    bus.in_mask = 16'h8000;
    #1;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_pos !== 4'd0 || bus.out_last !== 1'b1 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_first got v%b pos %0d last %b in_ready %b want 1 0 1 1",
                        bus.out_valid, bus.out_pos, bus.out_last, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_pos !== 4'd15 || bus.out_idx !== 4'd0 || bus.out_last !== 1'b1) begin
      fails++; $display("FAIL b2b_second got v%b pos %0d idx %0d last %b want 1 15 0 1",
                        bus.out_valid, bus.out_pos, bus.out_idx, bus.out_last);
    end
    step();
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_done out_valid %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_sequence();
    bus.out_ready = 1'b1;
    offer_mask(16'h00F0, "rst");
    tests++;
    if (bus.out_pos !== 4'd7) begin fails++; $display("FAIL rst_beat0 pos %0d want 7", bus.out_pos); end
    step();
    tests++;
    if (bus.out_pos !== 4'd6 || bus.out_idx !== 4'd1) begin
      fails++; $display("FAIL rst_beat1 pos %0d idx %0d want 6 1", bus.out_pos, bus.out_idx);
    end
    step();
    // Beat pos 5 is on offer with out_ready high; reset must win at this edge.
    reset = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (bus.out_valid !== 1'b0 || state_dbg !== IDLE || bus.in_ready !== 1'b1) begin
        fails++; $display("FAIL rst_hold%0d out_valid %b state %0d in_ready %b want 0 IDLE 1",
                          k, bus.out_valid, state_dbg, bus.in_ready);
      end
      if (k == 0) reset = 1'b1;
      step();
    end
    offer_mask(16'h0002, "rst_next");
    tests++;
    if (bus.out_pos !== 4'd1 || bus.out_idx !== 4'd0 || bus.out_last !== 1'b1 || bus.out_zero !== 1'b0) begin
      fails++; $display("FAIL rst_next_beat pos %0d idx %0d last %b zero %b want 1 0 1 0",
                        bus.out_pos, bus.out_idx, bus.out_last, bus.out_zero);
    end
    step();
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_next_done out_valid %b want 0", bus.out_valid); end
  endtask

  // Test sequence and final report
  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_mask = 16'h0000;
    bus.out_ready = 1'b0;
    test_reset();
    test_sequence();
    test_zero_mask();
    test_full_mask();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_sequence();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
